aes_encipher_block_xl: RTL and testbench

- Parametrised next-generation AES encipher round engine. Supports AES-128, AES-192 and AES-256.
- S-box throughput is configurable: 1, 2 or 4 words substituted per cycle.
- Sits between the key memory, which is indexed by `round`, and the shared external S-box array. The core control FSM drives `next` and `keylen`, and consumes `new_block` when `ready` is high.

---
 rtl/aes_encipher_block_xl.sv | 175 +++++++++++++++++
 tb/tb_aes_encipher_block_xl.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_encipher_block_xl.sv
// AES-128/192/256 encipher round engine with 1/2/4 S-box lanes; result ready Nr*(4/SBOX_LANES+1)+1 edges after next.
// No backpressure: S-box and round key return combinationally, next is only honoured in IDLE.
module aes_encipher_block_xl #(
    parameter int SBOX_LANES = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    next,
    input  logic [1:0]              keylen,
    output logic [3:0]              round,
    input  logic [127:0]            round_key,
    output logic [32*SBOX_LANES-1:0] sboxw,
    input  logic [32*SBOX_LANES-1:0] new_sboxw,
    input  logic [127:0]            block,
    output logic [127:0]            new_block,
    output logic                    ready
);

    localparam int S = (SBOX_LANES > 0) ? (4 / SBOX_LANES) : 1;
    localparam logic [1:0] CTR_LAST = 2'(S - 1);

    generate
        if (!(SBOX_LANES == 1 || SBOX_LANES == 2 || SBOX_LANES == 4)) begin : g_bad_lanes
            $error("aes_encipher_block_xl: SBOX_LANES must be 1, 2 or 4");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_SBOX,
        ST_MAIN,
        ST_FINAL
    } fsm_t;

    // Element 0 is the most significant word, so w0 lands in bits [127:96].
    typedef logic [0:3][31:0] aes_state_t;

    fsm_t       r_fsm;
    fsm_t       w_fsm_nxt;
    aes_state_t r_blk;
    aes_state_t w_sub_blk;
    logic [3:0] r_round;
    logic [3:0] w_nr;
    logic [1:0] r_ctr;
    logic [1:0] r_keylen;
    logic [1:0] w_idx;
    logic       r_ready;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_word(input logic [31:0] w);
        logic [7:0] b0, b1, b2, b3;
        b0 = w[31:24];
        b1 = w[23:16];
        b2 = w[15:8];
        b3 = w[7:0];
        return {xtime(b0) ^ xtime(b1) ^ b1 ^ b2 ^ b3,
                b0 ^ xtime(b1) ^ xtime(b2) ^ b2 ^ b3,
                b0 ^ b1 ^ xtime(b2) ^ xtime(b3) ^ b3,
                xtime(b0) ^ b0 ^ b1 ^ b2 ^ xtime(b3)};
    endfunction

    function automatic aes_state_t mix_columns(input aes_state_t s);
        aes_state_t o;
        for (int c = 0; c < 4; c++) begin
            o[c] = mix_word(s[c]);
        end
        return o;
    endfunction

    // Row r of column c takes row r of column (c+r) mod 4.
    function automatic aes_state_t shift_rows(input aes_state_t s);
        aes_state_t o;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[c][31-8*r -: 8] = s[(c + r) % 4][31-8*r -: 8];
            end
        end
        return o;
    endfunction

    always_comb begin
        case (r_keylen)
            2'b01:   w_nr = 4'd12;
            2'b10:   w_nr = 4'd14;
            default: w_nr = 4'd10;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fsm <= ST_IDLE;
        end else begin
            r_fsm <= w_fsm_nxt;
        end
    end

    always_comb begin
        w_fsm_nxt = r_fsm;
        case (r_fsm)
            ST_IDLE:  if (next) w_fsm_nxt = ST_INIT;
            ST_INIT:  w_fsm_nxt = ST_SBOX;
            ST_SBOX: begin
                if (r_ctr == CTR_LAST) begin
                    w_fsm_nxt = (r_round < w_nr) ? ST_MAIN : ST_FINAL;
                end
            end
            ST_MAIN:  w_fsm_nxt = ST_SBOX;
            ST_FINAL: w_fsm_nxt = ST_IDLE;
            default:  w_fsm_nxt = ST_IDLE;
        endcase
    end

    // Lane k handles word ctr*SBOX_LANES+k; substituted words merge into the next state.
    always_comb begin
        sboxw     = '0;
        w_sub_blk = r_blk;
        w_idx     = '0;
        if (r_fsm == ST_SBOX) begin
            for (int k = 0; k < SBOX_LANES; k++) begin
                w_idx                = 2'(int'(r_ctr) * SBOX_LANES + k);
                sboxw[32*k +: 32]    = r_blk[w_idx];
                w_sub_blk[w_idx]     = new_sboxw[32*k +: 32];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_blk    <= '0;
            r_round  <= '0;
            r_ctr    <= '0;
            r_keylen <= '0;
            r_ready  <= 1'b1;
        end else begin
            case (r_fsm)
                ST_IDLE: begin
                    if (next) begin
                        r_round  <= '0;
                        r_ready  <= 1'b0;
                        r_keylen <= keylen;
                    end
                end
                ST_INIT: begin
                    r_blk   <= block ^ round_key;
                    r_round <= 4'd1;
                    r_ctr   <= '0;
                end
                ST_SBOX: begin
                    r_blk <= w_sub_blk;
                    r_ctr <= (r_ctr == CTR_LAST) ? 2'd0 : r_ctr + 2'd1;
                end
                ST_MAIN: begin
                    r_blk   <= mix_columns(shift_rows(r_blk)) ^ round_key;
                    r_round <= r_round + 4'd1;
                end
                ST_FINAL: begin
                    // round stays at Nr so the key memory keeps pointing at the last key
                    r_blk   <= shift_rows(r_blk) ^ round_key;
                    r_ready <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign round     = r_round;
    assign new_block = r_blk;
    assign ready     = r_ready;

endmodule

// File: tb/tb_aes_encipher_block_xl.sv
// Bench for aes_encipher_block_xl: three instances (1, 2, 4 lanes) share stimulus;
// a per-instance scoreboard queue holds the expected ciphertext, latency and key set.
module tb_aes_encipher_block_xl;

    typedef struct {
        logic [1:0]      keylen;
        int              kid;
        logic [127:0]    pt;
        logic [127:0]    ct;
        logic [2:0][7:0] lat;   // {4 lanes, 2 lanes, 1 lane}
    } vec_t;

    typedef struct {
        logic [127:0] blk;
        int           lat;
        int           start;
        int           kid;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [2:0]   next_v;
    logic [1:0]   keylen;
    logic [127:0] block;

    logic         ready_v [3];
    logic [3:0]   round_v [3];
    logic [127:0] nb_v    [3];
    logic [127:0] sbx_v   [3];

    logic [7:0]   sbox_tab [256];
    logic [127:0] rk_tab   [4][15];
    int           cur_kid  [3];
    int           last_hi  [3];
    exp_t         sb_q     [3][$];

    int   cyc    = 0;
    int   checks = 0;
    int   fails  = 0;
    vec_t vt [4];
    vec_t v2;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp_v);
        end
    endtask

    function automatic logic [7:0] xt8(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = xt8(aa);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return 8'((x << n) | (x >> (8 - n)));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++) begin
                if (a != 0 && gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            end
            sbox_tab[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
    endfunction

    task automatic expand_key(input logic [255:0] key, input int nk, input int kid);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        int          nr;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt8(rc);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r <= nr; r++) rk_tab[kid][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int L = 1 << g;
        logic [32*L-1:0] sw;
        logic [32*L-1:0] nsw;
        logic [3:0]      rnd;
        logic [127:0]    rk;
        logic [127:0]    nb;
        logic            rdy;
        logic            prev = 1'b1;
        int              hi = 0;

        for (genvar b = 0; b < 4 * L; b++) begin : g_sb
            assign nsw[8*b +: 8] = sbox_tab[sw[8*b +: 8]];
        end
        assign rk         = rk_tab[cur_kid[g]][rnd];
        assign ready_v[g] = rdy;
        assign round_v[g] = rnd;
        assign nb_v[g]    = nb;
        assign sbx_v[g]   = 128'(sw);

        aes_encipher_block_xl #(.SBOX_LANES(L)) u_dut (
            .clk       (clk),
            .reset_n   (reset_n),
            .next      (next_v[g]),
            .keylen    (keylen),
            .round     (rnd),
            .round_key (rk),
            .sboxw     (sw),
            .new_sboxw (nsw),
            .block     (block),
            .new_block (nb),
            .ready     (rdy)
        );

        always @(posedge clk) begin
            #1;
            if (!reset_n) begin
                prev = rdy;
                hi   = 0;
            end else begin
                if (rdy) hi++;
                else if (prev) begin
                    last_hi[g] = hi;
                    hi = 0;
                end
                if (rdy && !prev) begin
                    if (sb_q[g].size() == 0) begin
                        checks++;
                        fails++;
                        $display("FAIL unexpected_done_L%0d actual=ready required=no_completion", L);
                    end else begin
                        exp_t e;
                        e = sb_q[g].pop_front();
                        chk($sformatf("result_L%0d", L), nb, e.blk);
                        chk($sformatf("latency_L%0d", L), 128'(cyc - e.start), 128'(e.lat));
                        if (sb_q[g].size() != 0) cur_kid[g] = sb_q[g][0].kid;
                    end
                end
                prev = rdy;
            end
        end
    end

    task automatic start_op(input vec_t v, input bit hold);
        @(negedge clk);
        keylen = v.keylen;
        block  = v.pt;
        for (int i = 0; i < 3; i++) begin
            if (sb_q[i].size() == 0) cur_kid[i] = v.kid;
            sb_q[i].push_back('{v.ct, int'(v.lat[i]), cyc + 1, v.kid});
        end
        next_v = 3'b111;
        @(negedge clk);
        if (!hold) next_v = 3'b000;
    endtask

    task automatic flush_q();
        for (int i = 0; i < 3; i++) sb_q[i].delete();
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((sb_q[0].size() + sb_q[1].size() + sb_q[2].size()) != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if ((sb_q[0].size() + sb_q[1].size() + sb_q[2].size()) != 0) begin
            checks++;
            fails++;
            $display("FAIL completion_timeout actual=pending required=done_within_%0d", budget);
            flush_q();
        end
    endtask

    task automatic check_reset(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s_ready_%0d", tag, i), 128'(ready_v[i]), 128'(1));
            chk($sformatf("%s_block_%0d", tag, i), nb_v[i], 128'h0);
            chk($sformatf("%s_round_%0d", tag, i), 128'(round_v[i]), 128'h0);
            chk($sformatf("%s_sboxw_%0d", tag, i), sbx_v[i], 128'h0);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]   obs [52];
        logic [3:0]   dl [$];
        logic [127:0] got;
        int           dwell1;
        int           n;
        int           s;
        int           s2 [3];

        reset_n = 1'b0;
        next_v  = 3'b000;
        keylen  = 2'b00;
        block   = '0;
        for (int i = 0; i < 3; i++) begin
            cur_kid[i] = 0;
            last_hi[i] = 0;
        end

        build_sbox();
        expand_key({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, 0);
        expand_key({192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, 6, 1);
        expand_key(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, 2);
        expand_key({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4, 3);

        vt[0] = '{2'b00, 0, 128'h00112233445566778899aabbccddeeff,
                  128'h69c4e0d86a7b0430d8cdb78070b4c55a, {8'd21, 8'd31, 8'd51}};
        vt[1] = '{2'b01, 1, 128'h00112233445566778899aabbccddeeff,
                  128'hdda97ca4864cdfe06eaf70a0ec0d7191, {8'd25, 8'd37, 8'd61}};
        vt[2] = '{2'b10, 2, 128'h00112233445566778899aabbccddeeff,
                  128'h8ea2b7ca516745bfeafc49904b496089, {8'd29, 8'd43, 8'd71}};
        vt[3] = '{2'b11, 0, 128'h00112233445566778899aabbccddeeff,
                  128'h69c4e0d86a7b0430d8cdb78070b4c55a, {8'd21, 8'd31, 8'd51}};
        v2    = '{2'b00, 3, 128'h3243f6a8885a308d313198a2e0370734,
                  128'h3925841d02dc09fbdc118597196a0b32, {8'd21, 8'd31, 8'd51}};

        repeat (3) @(negedge clk);
        check_reset("por");
        reset_n = 1'b1;

        // Round address sequence on the single-lane instance.
        start_op(vt[0], 1'b0);
        obs[0] = round_v[0];
        for (int k = 1; k < 52; k++) begin
            @(negedge clk);
            obs[k] = round_v[0];
        end
        dwell1 = 0;
        for (int k = 0; k < 52; k++) begin
            if (k == 0 || obs[k] != obs[k-1]) dl.push_back(obs[k]);
            if (obs[k] == 4'd1) dwell1++;
        end
        chk("round_seq_len", 128'(dl.size()), 128'd11);
        for (int j = 0; j < 11; j++) begin
            if (j < dl.size()) got = 128'(dl[j]);
            else got = 128'hdead;
            chk($sformatf("round_seq_%0d", j), got, 128'(j));
        end
        chk("round1_dwell", 128'(dwell1), 128'd5);
        wait_idle(100);

        for (int v = 0; v < 4; v++) begin
            start_op(vt[v], 1'b0);
            wait_idle(100);
        end

        // Busy-time next pulses, keylen and block changes must not disturb the operation.
        start_op(vt[0], 1'b0);
        repeat (3) @(negedge clk);
        next_v = 3'b111;
        keylen = 2'b10;
        block  = ~vt[0].pt;
        @(negedge clk);
        next_v = 3'b000;
        keylen = 2'b01;
        repeat (5) @(negedge clk);
        next_v = 3'b111;
        keylen = 2'b11;
        @(negedge clk);
        next_v = 3'b000;
        keylen = 2'b10;
        block  = '0;
        wait_idle(100);

        // Reset in round 5, then a clean operation.
        start_op(vt[0], 1'b0);
        n = 0;
        while (round_v[0] != 4'd5 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (round_v[0] != 4'd5) begin
            checks++;
            fails++;
            $display("FAIL reach_round5 actual=%0d required=5", round_v[0]);
        end
        reset_n = 1'b0;
        #1;
        check_reset("mid");
        flush_q();
        for (int i = 0; i < 3; i++) cur_kid[i] = 0;
        @(negedge clk);
        reset_n = 1'b1;
        start_op(vt[0], 1'b0);
        wait_idle(100);

        // Back-to-back with next held high: second op uses a different key and plaintext.
        start_op(vt[0], 1'b1);
        s = cyc;
        @(negedge clk);
        block = v2.pt;
        for (int i = 0; i < 3; i++) begin
            s2[i] = s + int'(vt[0].lat[i]) + 1;
            sb_q[i].push_back('{v2.ct, int'(v2.lat[i]), s2[i], v2.kid});
        end
        n = 0;
        while (next_v != 3'b000 && n < 200) begin
            @(negedge clk);
            n++;
            for (int i = 0; i < 3; i++) begin
                if (next_v[i] && cyc >= s2[i]) next_v[i] = 1'b0;
            end
        end
        next_v = 3'b000;
        wait_idle(200);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("b2b_ready_width_%0d", i), 128'(last_hi[i]), 128'd1);
        end

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
